// File: rtl/regif_rr_arbiter.sv
// regif_rr_arbiter: round-robin arbiter serialising N_REQ requesters onto one register-file port (grant lock via SRDL2SV_ARB_LOCK_EN)
module regif_rr_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         bus_clk,
  input  logic                         bus_rst,
  input  logic [N_REQ-1:0]             req_vld,
  input  logic [N_REQ-1:0]             req_write,
  input  logic [N_REQ*ADDR_W-1:0]      req_addr,
  input  logic [N_REQ*(DATA_W/8)-1:0]  req_be,
  input  logic [N_REQ*DATA_W-1:0]      req_wdata,
  input  logic [N_REQ-1:0]             req_lock,
  output logic [N_REQ-1:0]             req_ack,
  output logic [DATA_W-1:0]            req_rdata,
  output logic [ADDR_W-1:0]            addr,
  output logic                         w_vld,
  output logic                         r_vld,
  output logic [DATA_W/8-1:0]          byte_enable,
  output logic [DATA_W-1:0]            sw_wr_bus,
  input  logic [DATA_W-1:0]            sw_rd_bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;
  state_t state;
  logic [IW-1:0] last, win, pick, idx, grant;
  logic keep;
  always_comb begin
    pick = last;
    idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % N_REQ);
      pick = req_vld[idx] ? idx : pick;
    end
  end
`ifdef SRDL2SV_ARB_LOCK_EN
  logic locked;
  assign keep = locked && req_vld[win];
  always_ff @(posedge bus_clk)
    if (bus_rst) locked <= 1'b0;
    else if (state == ACK) locked <= req_lock[win];
    else if (state == IDLE) locked <= 1'b0;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign keep = 1'b0;
`endif
  assign grant = keep ? win : pick;
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state       <= IDLE;
      last        <= IW'(N_REQ - 1);
      win         <= '0;
      addr        <= '0;
      byte_enable <= '0;
      sw_wr_bus   <= '0;
      w_vld       <= 1'b0;
      r_vld       <= 1'b0;
      req_ack     <= '0;
      req_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (|req_vld) begin
          win         <= grant;
          last        <= keep ? last : grant;
          addr        <= req_addr[grant*ADDR_W +: ADDR_W];
          byte_enable <= req_be[grant*BW +: BW];
          sw_wr_bus   <= req_wdata[grant*DATA_W +: DATA_W];
          w_vld       <= req_write[grant];
          r_vld       <= !req_write[grant];
          state       <= ISSUE;
        end
        ISSUE: begin
          w_vld     <= 1'b0;
          r_vld     <= 1'b0;
          req_ack   <= N_REQ'(1) << win;
          req_rdata <= r_vld ? sw_rd_bus : '0;
          state     <= ACK;
        end
        ACK: begin
          req_ack   <= '0;
          req_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regif_rr_arbiter.sv
// tb_regif_rr_arbiter: directed self-checking bench for regif_rr_arbiter with four requesters
module tb_regif_rr_arbiter;
  localparam int N = 4;
  logic bus_clk = 1'b0;
  logic bus_rst = 1'b1;
  logic [N-1:0] req_vld = '0, req_write = '0, req_lock = '0;
  logic [N*32-1:0] req_addr = '0, req_wdata = '0;
  logic [N*4-1:0] req_be = '0;
  logic [N-1:0] req_ack;
  logic [31:0] req_rdata, addr, sw_wr_bus;
  logic [31:0] sw_rd_bus = '0;
  logic w_vld, r_vld;
  logic [3:0] byte_enable;
  int errors = 0;
  int checks = 0;
  always #5 bus_clk = ~bus_clk;
  regif_rr_arbiter #(.N_REQ(N), .ADDR_W(32), .DATA_W(32)) dut (
    .bus_clk(bus_clk), .bus_rst(bus_rst), .req_vld(req_vld), .req_write(req_write),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_lock(req_lock),
    .req_ack(req_ack), .req_rdata(req_rdata), .addr(addr), .w_vld(w_vld), .r_vld(r_vld),
    .byte_enable(byte_enable), .sw_wr_bus(sw_wr_bus), .sw_rd_bus(sw_rd_bus)
  );
  task automatic tick(input int n = 1);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    req_write[i] = wr;
    req_addr[i*32 +: 32] = a;
    req_be[i*4 +: 4] = be;
    req_wdata[i*32 +: 32] = d;
  endtask
  task automatic do_reset();
    bus_rst = 1'b1;
    tick();
    bus_rst = 1'b0;
  endtask
  task automatic test_reset();
    bus_rst = 1'b1;
    req_vld = 4'b0001;
    tick(2);
    checks++;
    if ({req_ack, req_rdata, addr, w_vld, r_vld, byte_enable, sw_wr_bus} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b rdata=%h addr=%h w=%b r=%b be=%h wd=%h required all 0", req_ack, req_rdata, addr, w_vld, r_vld, byte_enable, sw_wr_bus);
    end
    req_vld = '0;
    bus_rst = 1'b0;
    tick();
  endtask
  task automatic test_single_read();
    set_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
    req_vld = 4'b0001;
    tick();
    checks++;
    if ({r_vld, w_vld} !== 2'b10 || addr !== 32'h10) begin
      errors++;
      $display("FAIL read_strobe: got r=%b w=%b addr=%h required r=1 w=0 addr=10", r_vld, w_vld, addr);
    end
    sw_rd_bus = 32'hDEADBEEF;
    tick();
    sw_rd_bus = '0;
    checks++;
    if (req_ack !== 4'b0001) begin
      errors++;
      $display("FAIL read_ack: got %b required 0001", req_ack);
    end
    checks++;
    if (req_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_rdata: got %h required deadbeef", req_rdata);
    end
    req_vld = '0;
    tick();
    checks++;
    if (req_ack !== 4'b0000 || req_rdata !== 32'h0 || r_vld !== 1'b0) begin
      errors++;
      $display("FAIL read_after: got ack=%b rdata=%h r=%b required 0", req_ack, req_rdata, r_vld);
    end
  endtask
  task automatic test_single_write();
    set_req(1, 1'b1, 32'h4, 4'h3, 32'h1234);
    sw_rd_bus = 32'hBAD0BAD0;
    req_vld = 4'b0010;
    tick();
    checks++;
    if ({w_vld, r_vld} !== 2'b10 || addr !== 32'h4 || byte_enable !== 4'h3 || sw_wr_bus !== 32'h1234) begin
      errors++;
      $display("FAIL write_strobe: got w=%b r=%b addr=%h be=%h wd=%h required w=1 r=0 addr=4 be=3 wd=1234", w_vld, r_vld, addr, byte_enable, sw_wr_bus);
    end
    tick();
    checks++;
    if (req_ack !== 4'b0010 || req_rdata !== 32'h0) begin
      errors++;
      $display("FAIL write_ack: got ack=%b rdata=%h required ack=0010 rdata=0", req_ack, req_rdata);
    end
    req_vld = '0;
    sw_rd_bus = '0;
    tick();
    checks++;
    if (addr !== 32'h4 || w_vld !== 1'b0 || sw_wr_bus !== 32'h1234) begin
      errors++;
      $display("FAIL write_hold: got addr=%h w=%b wd=%h required addr=4 w=0 wd=1234", addr, w_vld, sw_wr_bus);
    end
  endtask
  task automatic test_contention();
    logic [N-1:0] exp;
    do_reset();
    set_req(0, 1'b0, 32'h20, 4'hF, 32'h0);
    set_req(1, 1'b1, 32'h24, 4'hF, 32'h77);
    req_vld = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 1) ? 4'b0010 : 4'b0001;
      tick(k == 0 ? 1 : 2);
      checks++;
      if (req_ack !== 4'b0000) begin
        errors++;
        $display("FAIL contention_gap%0d: got %b required 0000", k, req_ack);
      end
      tick();
      checks++;
      if (req_ack !== exp) begin
        errors++;
        $display("FAIL contention_ack%0d: got %b required %b", k, req_ack, exp);
      end
    end
    req_vld = '0;
    tick();
  endtask
  task automatic test_wrap();
    do_reset();
    set_req(3, 1'b0, 32'h30, 4'hF, 32'h0);
    req_vld = 4'b1000;
    tick(2);
    checks++;
    if (req_ack !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_first: got %b required 1000", req_ack);
    end
    set_req(0, 1'b0, 32'h34, 4'hF, 32'h0);
    req_vld = 4'b1001;
    tick(3);
    checks++;
    if (req_ack !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_zero: got %b required 0001", req_ack);
    end
    tick(3);
    checks++;
    if (req_ack !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_three: got %b required 1000", req_ack);
    end
    req_vld = '0;
    tick();
  endtask
  task automatic test_reset_in_issue();
    set_req(1, 1'b1, 32'h44, 4'hF, 32'h55);
    req_vld = 4'b0010;
    tick();
    checks++;
    if (w_vld !== 1'b1 || addr !== 32'h44) begin
      errors++;
      $display("FAIL rst_issue_pre: got w=%b addr=%h required w=1 addr=44", w_vld, addr);
    end
    bus_rst = 1'b1;
    set_req(0, 1'b0, 32'h40, 4'hF, 32'h0);
    set_req(2, 1'b1, 32'h48, 4'hF, 32'h99);
    req_vld = 4'b0101;
    tick();
    bus_rst = 1'b0;
    checks++;
    if ({req_ack, req_rdata, addr, w_vld, r_vld, byte_enable, sw_wr_bus} !== '0) begin
      errors++;
      $display("FAIL rst_issue_clear: got ack=%b rdata=%h addr=%h w=%b r=%b be=%h wd=%h required all 0", req_ack, req_rdata, addr, w_vld, r_vld, byte_enable, sw_wr_bus);
    end
    tick();
    checks++;
    if (req_ack !== 4'b0000 || r_vld !== 1'b1 || addr !== 32'h40) begin
      errors++;
      $display("FAIL rst_issue_regrant: got ack=%b r=%b addr=%h required ack=0000 r=1 addr=40", req_ack, r_vld, addr);
    end
    sw_rd_bus = 32'hCAFEF00D;
    tick();
    sw_rd_bus = '0;
    checks++;
    if (req_ack !== 4'b0001 || req_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rst_issue_ack: got ack=%b rdata=%h required ack=0001 rdata=cafef00d", req_ack, req_rdata);
    end
    req_vld = '0;
    tick();
  endtask
  task automatic test_lock();
    do_reset();
    set_req(1, 1'b1, 32'h60, 4'hF, 32'h1);
    req_lock = 4'b0010;
    req_vld = 4'b0010;
    tick(2);
    checks++;
    if (req_ack !== 4'b0010) begin
      errors++;
      $display("FAIL lock_first: got %b required 0010", req_ack);
    end
    set_req(0, 1'b0, 32'h50, 4'hF, 32'h0);
    set_req(1, 1'b1, 32'h60, 4'hF, 32'h2);
    req_vld = 4'b0011;
`ifdef SRDL2SV_ARB_LOCK_EN
    tick(2);
    checks++;
    if (w_vld !== 1'b1 || sw_wr_bus !== 32'h2) begin
      errors++;
      $display("FAIL lock_second_wr: got w=%b wd=%h required w=1 wd=2", w_vld, sw_wr_bus);
    end
    tick();
    checks++;
    if (req_ack !== 4'b0010) begin
      errors++;
      $display("FAIL lock_second_ack: got %b required 0010", req_ack);
    end
    set_req(1, 1'b1, 32'h60, 4'hF, 32'h3);
    tick(2);
    checks++;
    if (w_vld !== 1'b1 || sw_wr_bus !== 32'h3) begin
      errors++;
      $display("FAIL lock_third_wr: got w=%b wd=%h required w=1 wd=3", w_vld, sw_wr_bus);
    end
    tick();
    checks++;
    if (req_ack !== 4'b0010) begin
      errors++;
      $display("FAIL lock_third_ack: got %b required 0010", req_ack);
    end
    req_lock = '0;
    req_vld = 4'b0001;
    tick(3);
    checks++;
    if (req_ack !== 4'b0001) begin
      errors++;
      $display("FAIL lock_release: got %b required 0001", req_ack);
    end
`else
    tick(3);
    checks++;
    if (req_ack !== 4'b0001) begin
      errors++;
      $display("FAIL lock_ignored: got %b required 0001", req_ack);
    end
    req_vld = 4'b0010;
    tick(3);
    checks++;
    if (req_ack !== 4'b0010) begin
      errors++;
      $display("FAIL lock_ignored_next: got %b required 0010", req_ack);
    end
`endif
    req_vld = '0;
    req_lock = '0;
    tick();
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_wrap();
    test_reset_in_issue();
    test_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regif_rr_arbiter.md
# regif_rr_arbiter

Round-robin arbiter that lets N_REQ bus-protocol widgets share the single internal register-file access port (addr, w_vld, r_vld, byte_enable, sw_wr_bus, sw_rd_bus). It sits between the bus widgets and the generated register block. It serialises requests into one access at a time, captures read data and returns a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte_enable width is DATA_W/8

Ports:
- bus_clk  in  1  register clock; all logic on rising edge
- bus_rst  in  1  reset, synchronous and active-high
- req_vld  in  N_REQ  per-requester request; held high until its ack
- req_write  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  packed per-requester address
- req_be  in  N_REQ*(DATA_W/8)  packed byte enables
- req_wdata  in  N_REQ*DATA_W  packed write data
- req_lock  in  N_REQ  keep grant after transfer (only with SRDL2SV_ARB_LOCK_EN)
- req_ack  out  N_REQ  one-cycle completion pulse, one-hot
- req_rdata  out  DATA_W  read data, valid in ack cycle for reads, else 0
- addr  out  ADDR_W  register-file address
- w_vld  out  1  write strobe
- r_vld  out  1  read strobe
- byte_enable  out  DATA_W/8  byte enables
- sw_wr_bus  out  DATA_W  write data
- sw_rd_bus  in  DATA_W  read data, combinationally valid in the r_vld cycle

## Operation
- FSM states: IDLE, ISSUE, ACK.
- IDLE: if any req_vld is set, select a winner, latch its write/addr/be/wdata into output registers, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive exactly one of w_vld/r_vld high, capture sw_rd_bus into rdata register if read, then go to ACK.
- ACK: pulse req_ack[winner], present rdata, then go to IDLE.
- Round-robin: last pointer holds the index of the last winner. The new winner is the first requesting index after last, searching upward modulo N_REQ. last is updated on entry to ISSUE.
- Requester contract: req_* stable from req_vld rise until ack. req_vld must drop in the cycle after ack. Changing req_* mid-transfer has no effect because the request is latched in IDLE.
- Deassertion of req_vld before ack is illegal. The latched transfer still completes and acks.
- addr/byte_enable/sw_wr_bus hold their last value outside ISSUE. w_vld/r_vld are 0 outside ISSUE.
- req_rdata is 0 except in the ACK cycle of a read.

## Timing
- Reset values: state IDLE, last = N_REQ-1 (index 0 wins first), req_ack 0, req_rdata 0, addr 0, w_vld 0, r_vld 0, byte_enable 0, sw_wr_bus 0.
- Latency: req_vld seen at cycle 0 edge; strobe in cycle 1; ack in cycle 2. One transfer per 3 cycles max.
- Simultaneous requests: exactly one wins per IDLE decision. With continuous contention each of the N_REQ requesters wins once per N_REQ transfers.
- Wrap-around: last = N_REQ-1 with requesters 0 and N_REQ-1 pending gives winner 0.
- Reset mid-transfer: in-flight strobe/ack is cancelled the next edge. No ack is issued for that transfer. The pointer returns to N_REQ-1.

## Configuration
- SRDL2SV_ARB_LOCK_EN defined: in ACK, if req_lock[winner] is set, the next IDLE decision grants the same requester, if its req_vld is high, regardless of round-robin. last is not advanced for locked re-grants. If the locked requester has no request in that IDLE cycle, the lock is released and round-robin resumes.
- Not defined: req_lock is ignored and pure round-robin applies.

## Test plan
- Single read: req 0 read addr 0x10, sw_rd_bus=0xDEADBEEF in the r_vld cycle -> r_vld in cycle 1, req_ack=01 and req_rdata=0xDEADBEEF in cycle 2.
- Single write: req 1 write addr 0x4, be=0x3, wdata=0x1234 -> w_vld with addr 0x4/byte_enable 0x3/sw_wr_bus 0x1234 in cycle 1; ack=10 in cycle 2; req_rdata 0.
- Contention after reset: req 0 and req 1 both held -> grant order 0,1,0,1, with acks 3 cycles apart.
- Wrap: N_REQ=4, requests on 3 then 0 and 3 together after 3 won -> 0 wins next.
- Reset in ISSUE: assert bus_rst during a w_vld cycle -> next cycle all outputs 0, no ack; the first post-reset grant goes to index 0.
- With SRDL2SV_ARB_LOCK_EN: req 1 locked with 3 back-to-back writes while req 0 pending -> 3 acks to req 1, then req 0 is served once lock drops.
